// File: rtl/round_sequencer_pkg.sv
// Shared types and constants for the memory-game round sequencer.
// State enum, level one-hot codes, compare masks, timer loads, score helper.
package round_sequencer_pkg;

  localparam int NUM_ROUNDS     = 10;
  localparam int SUB_RST_CYCLES = 3;
  localparam int SETTLE_CYCLES  = 2;
  localparam int GAP_CYCLES     = 4;
  localparam int SCORE_PER_WIN  = 10;

  localparam int TMR_W = 2;

  // Timer is loaded with N-1 so the owning state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] TMR_RST =
    TMR_W'(SUB_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_SETTLE =
    TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_GAP =
    TMR_W'(GAP_CYCLES - 1);

  localparam logic [4:0] ROUNDS_MAX = 5'(NUM_ROUNDS);
  localparam logic [3:0] WINS_MAX   = 4'(NUM_ROUNDS);

  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;

  localparam logic [15:0] LV_MASK_L1 = 16'h00FF;
  localparam logic [15:0] LV_MASK_L2 = 16'h0FFF;
  localparam logic [15:0] LV_MASK_L3 = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROUND_RST,
    S_GEN,
    S_PRINT,
    S_INPUT,
    S_SETTLE,
    S_SCORE,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic lv_onehot(
    input logic [2:0] lv
  );
    return (lv == LV1) || (lv == LV2) ||
           (lv == LV3);
  endfunction

  function automatic logic [15:0] lv_to_mask(
    input logic [2:0] lv
  );
    logic [15:0] m;
    m = 16'h0000;
    unique case (1'b1)
      lv[0]: m = LV_MASK_L1;
      lv[1]: m = LV_MASK_L2;
      lv[2]: m = LV_MASK_L3;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // 10*n as 8n + 2n; falls back to a multiply
  // only if the per-win score is ever changed.
  function automatic logic [6:0] calc_score(
    input logic [3:0] n
  );
    logic [6:0] s;
    if (SCORE_PER_WIN == 10) begin
      s = {n, 3'b000} + {2'b00, n, 1'b0};
    end else begin
      s = 7'(n * SCORE_PER_WIN);
    end
    return s;
  endfunction

endpackage

// File: rtl/round_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag, shared by the timed states.
// Ports: clk_1, rst (async low), load/load_val, zero.
module round_sequencer_cycle_timer
  import round_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_1,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Round FSM for the memory game: sequences gen/print/input, counts rounds.
// Ports: clk_1, rst, level/start/done handshakes in; sub_rst_n, enables, mask, counts, score out.
module round_sequencer
  import round_sequencer_pkg::*;
(
  input  logic        clk_1,
  input  logic        rst,
  input  logic        level_valid,
  input  logic [2:0]  level,
  input  logic        start,
  input  logic        gen_done,
  input  logic        print_done,
  input  logic        input_done,
  input  logic        round_win,
  output logic        sub_rst_n,
  output logic        gen_en,
  output logic        print_en,
  output logic        input_en,
  output logic [15:0] lv_mask,
  output logic [4:0]  round_count,
  output logic [3:0]  answer_count,
  output logic [6:0]  score,
  output logic        game_over
);

  state_e state_q, state_d;

  logic start_q;
  logic start_rise;
  logic lv_ok;

  logic [2:0]  level_q, level_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  rc_q, rc_d;
  logic [3:0]  ac_q, ac_d;
  logic [6:0]  score_q, score_d;

  logic sub_rst_q, sub_rst_d;
  logic gen_q, gen_d;
  logic print_q, print_d;
  logic input_q, input_d;
  logic go_q, go_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  assign start_rise = start & ~start_q;
  assign lv_ok = level_valid & lv_onehot(level);

  round_sequencer_cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk_1   (clk_1),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    mask_d  = mask_q;
    rc_d    = rc_q;
    ac_d    = ac_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise && lv_ok) begin
          state_d = S_ROUND_RST;
          level_d = level;
          mask_d  = lv_to_mask(level);
        end
      end
      S_ROUND_RST: begin
        if (tmr_zero) state_d = S_GEN;
      end
      S_GEN: begin
        if (gen_done) state_d = S_PRINT;
      end
      S_PRINT: begin
        if (print_done) state_d = S_INPUT;
      end
      S_INPUT: begin
        if (input_done) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_zero) state_d = S_SCORE;
      end
      S_SCORE: begin
        rc_d = rc_q + 1'b1;
        if (round_win && (ac_q < WINS_MAX)) begin
          ac_d = ac_q + 4'd1;
        end
        if (rc_d == ROUNDS_MAX) begin
          state_d = S_DONE;
          score_d = calc_score(ac_d);
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_zero) state_d = S_ROUND_RST;
      end
      S_DONE: begin
        // Replay keeps the latched level.
        if (start_rise) begin
          state_d = S_ROUND_RST;
          rc_d    = '0;
          ac_d    = '0;
          score_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer reloads on every state change; only
  // the timed states ever look at its flag.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      S_ROUND_RST: tmr_val = TMR_RST;
      S_SETTLE:    tmr_val = TMR_SETTLE;
      S_GAP:       tmr_val = TMR_GAP;
      default:     tmr_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so
  // the registers line up with state_q.
  always_comb begin
    sub_rst_d = 1'b1;
    gen_d     = 1'b0;
    print_d   = 1'b0;
    input_d   = 1'b0;
    go_d      = 1'b0;
    case (state_d)
      S_IDLE, S_ROUND_RST: begin
        sub_rst_d = 1'b0;
      end
      S_GEN: begin
        gen_d = 1'b1;
      end
      S_PRINT: begin
        gen_d   = 1'b1;
        print_d = 1'b1;
      end
      S_INPUT, S_SETTLE, S_SCORE: begin
        gen_d   = 1'b1;
        print_d = 1'b1;
        input_d = 1'b1;
      end
      S_DONE: begin
        go_d = 1'b1;
      end
      default: begin
        sub_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      level_q   <= 3'b000;
      mask_q    <= 16'h0000;
      rc_q      <= '0;
      ac_q      <= '0;
      score_q   <= '0;
      sub_rst_q <= 1'b0;
      gen_q     <= 1'b0;
      print_q   <= 1'b0;
      input_q   <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      level_q   <= level_d;
      mask_q    <= mask_d;
      rc_q      <= rc_d;
      ac_q      <= ac_d;
      score_q   <= score_d;
      sub_rst_q <= sub_rst_d;
      gen_q     <= gen_d;
      print_q   <= print_d;
      input_q   <= input_d;
      go_q      <= go_d;
    end
  end

  assign sub_rst_n    = sub_rst_q;
  assign gen_en       = gen_q;
  assign print_en     = print_q;
  assign input_en     = input_q;
  assign lv_mask      = mask_q;
  assign round_count  = rc_q;
  assign answer_count = ac_q;
  assign score        = score_q;
  assign game_over    = go_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed game scenarios with random handshake delays.
// Expected counts and scores come from round-level arithmetic kept in the bench.
module tb_round_sequencer;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        level_valid;
  logic [2:0]  level;
  logic        start;
  logic        gen_done;
  logic        print_done;
  logic        input_done;
  logic        round_win;
  logic        sub_rst_n;
  logic        gen_en;
  logic        print_en;
  logic        input_en;
  logic [15:0] lv_mask;
  logic [4:0]  round_count;
  logic [3:0]  answer_count;
  logic [6:0]  score;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int exp_rc = 0;
  int exp_ac = 0;

  round_sequencer dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .level_valid (level_valid),
    .level       (level),
    .start       (start),
    .gen_done    (gen_done),
    .print_done  (print_done),
    .input_done  (input_done),
    .round_win   (round_win),
    .sub_rst_n   (sub_rst_n),
    .gen_en      (gen_en),
    .print_en    (print_en),
    .input_en    (input_en),
    .lv_mask     (lv_mask),
    .round_count (round_count),
    .answer_count(answer_count),
    .score       (score),
    .game_over   (game_over)
  );

  always #5 clk_1 = ~clk_1;

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sub_rst"}, {31'd0, sub_rst_n}, 0);
    chk({tag, "_en"},
        {29'd0, gen_en, print_en, input_en}, 0);
    chk({tag, "_mask"}, {16'd0, lv_mask}, 0);
    chk({tag, "_rc"}, {27'd0, round_count}, 0);
    chk({tag, "_ac"}, {28'd0, answer_count}, 0);
    chk({tag, "_score"}, {25'd0, score}, 0);
    chk({tag, "_go"}, {31'd0, game_over}, 0);
  endtask

  // Caller sets up the event that starts the
  // round-reset window on the next clock.
  task automatic enter_round(input logic [15:0] mask);
    for (int k = 0; k < 3; k++) begin
      tick();
      start = 1'b0;
      input_done = 1'b0;
      chk("rr_sub_rst", {31'd0, sub_rst_n}, 0);
      chk("rr_gen_en", {31'd0, gen_en}, 0);
      chk("rr_go", {31'd0, game_over}, 0);
      chk("rr_score", {25'd0, score}, 0);
      chk("rr_rc", {27'd0, round_count}, exp_rc);
      chk("rr_mask", {16'd0, lv_mask}, mask);
    end
    tick();
    chk("gen_on", {30'd0, gen_en, sub_rst_n}, 3);
    chk("gen_print_off", {31'd0, print_en}, 0);
  endtask

  task automatic gap_then_round(input logic [15:0] mask);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_en",
          {29'd0, gen_en, print_en, input_en}, 0);
      chk("gap_sub_rst", {31'd0, sub_rst_n}, 1);
    end
    enter_round(mask);
  endtask

  // Entered with the DUT just observed in GEN.
  task automatic play_round(input bit win,
                            input bit early,
                            input bit hold_in,
                            input bit start_ip,
                            input bit abort);
    int d;
    d = int'($urandom_range(0, 3));
    for (int k = 0; k < d; k++) begin
      tick();
      chk("gen_wait", {30'd0, gen_en, print_en}, 2);
    end
    gen_done = 1'b1;
    if (early) print_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk("print_on", {29'd0, gen_en, print_en, input_en}, 6);
    if (!early) begin
      d = int'($urandom_range(1, 3));
      for (int k = 0; k < d; k++) begin
        if (start_ip && k == 0) start = 1'b1;
        tick();
        start = 1'b0;
        chk("print_wait", {30'd0, print_en, input_en}, 2);
      end
      print_done = 1'b1;
    end
    tick();
    print_done = 1'b0;
    chk("input_on", {29'd0, gen_en, print_en, input_en}, 7);
    round_win = win;
    if (abort) begin
      #2 rst = 1'b0;
      #1 chk_reset_vals("abort");
      exp_rc = 0;
      exp_ac = 0;
      return;
    end
    d = int'($urandom_range(0, 3));
    for (int k = 0; k < d; k++) begin
      tick();
      chk("input_wait", {31'd0, input_en}, 1);
    end
    input_done = 1'b1;
    tick();
    if (!hold_in) input_done = 1'b0;
    chk("settle_rc", {27'd0, round_count}, exp_rc);
    tick();
    chk("settle2_rc", {27'd0, round_count}, exp_rc);
    tick();
    chk("score_rc", {27'd0, round_count}, exp_rc);
    tick();
    exp_rc++;
    if (win && exp_ac < 10) exp_ac++;
    chk("rc_upd", {27'd0, round_count}, exp_rc);
    chk("ac_upd", {28'd0, answer_count}, exp_ac);
    if (exp_rc == 10) begin
      chk("done_go", {31'd0, game_over}, 1);
      chk("done_score", {25'd0, score}, 10 * exp_ac);
    end else begin
      chk("gap_go", {31'd0, game_over}, 0);
      chk("gap_en0", {31'd0, gen_en}, 0);
    end
  endtask

  task automatic pulse_ignored(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk({tag, "_gen"}, {31'd0, gen_en}, 0);
    chk({tag, "_sub"}, {31'd0, sub_rst_n}, 0);
  endtask

  initial begin
    bit w;
    rst = 1'b0;
    level_valid = 1'b0;
    level = 3'b000;
    start = 1'b0;
    gen_done = 1'b0;
    print_done = 1'b0;
    input_done = 1'b0;
    round_win = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    @(negedge clk_1) rst = 1'b1;
    tick();

    level = 3'b000; level_valid = 1'b1;
    pulse_ignored("lv_zero");
    level = 3'b010; level_valid = 1'b0;
    pulse_ignored("lv_invalid");
    level = 3'b011; level_valid = 1'b1;
    pulse_ignored("lv_not_onehot");

    level = 3'b010; level_valid = 1'b1;
    start = 1'b1;
    enter_round(16'h0FFF);
    level = 3'b001; level_valid = 1'b0;
    for (int r = 0; r < 10; r++) begin
      play_round(r < 7, r == 1, r == 1, r == 0, 1'b0);
      if (r < 9) gap_then_round(16'h0FFF);
    end
    chk("g1_rc", {27'd0, round_count}, 10);
    chk("g1_ac", {28'd0, answer_count}, 7);
    chk("g1_score", {25'd0, score}, 70);

    start = 1'b1;
    exp_rc = 0;
    exp_ac = 0;
    enter_round(16'h0FFF);
    for (int r = 0; r < 3; r++) begin
      w = 1'($urandom_range(0, 1));
      play_round(w, 1'b0, 1'b0, 1'b0, 1'b0);
      gap_then_round(16'h0FFF);
    end
    play_round(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    round_win = 1'b0;
    input_done = 1'b0;
    start = 1'b0;
    @(negedge clk_1) rst = 1'b1;
    level = 3'b100;
    level_valid = 1'b1;
    start = 1'b1;
    enter_round(16'hFFFF);
    for (int r = 0; r < 10; r++) begin
      play_round(1'b1, 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b0);
      if (r < 9) gap_then_round(16'hFFFF);
    end
    chk("g3_score", {25'd0, score}, 100);
    level = 3'b010;
    start = 1'b1;
    exp_rc = 0;
    exp_ac = 0;
    enter_round(16'hFFFF);
    play_round(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("g4_rc", {27'd0, round_count}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
